// File: rtl/dcache_ctrl_if.sv
// Pipeline-side and memory-side signal bundle for dcache_ctrl.
// The cache sits on the slave modport and the pipeline/memory environment on the master modport.
interface dcache_ctrl_if;
   logic         MEM_R_EN;
   logic         MEM_W_EN;
   logic         is_byte;
   logic [31:0]  addr;
   logic [31:0]  wdata;
   logic [31:0]  rdata;
   logic         block_pipe_data_cache;
   logic         mem_req;
   logic         mem_we;
   logic [31:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ack;
   logic [15:0]  hit_count;
   logic [15:0]  miss_count;

   modport master (
      output MEM_R_EN, MEM_W_EN, is_byte, addr, wdata, mem_rdata, mem_ack,
      input  rdata, block_pipe_data_cache, mem_req, mem_we, mem_addr, mem_wdata,
             hit_count, miss_count
   );

   modport slave (
      input  MEM_R_EN, MEM_W_EN, is_byte, addr, wdata, mem_rdata, mem_ack,
      output rdata, block_pipe_data_cache, mem_req, mem_we, mem_addr, mem_wdata,
             hit_count, miss_count
   );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache with 16-byte lines.
// Define DCACHE_STATS_EN to build the saturating hit/miss counters; otherwise they read as zero.
module dcache_ctrl #(
   parameter int LINES = 4
) (
   input  logic         clk,
   input  logic         reset,
   dcache_ctrl_if.slave bus
);
   localparam int IDXW = $clog2(LINES);
   localparam int TAGW = 28 - IDXW;

   typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

   state_t state, state_nxt;

   logic [LINES-1:0] valid;
   logic [LINES-1:0] dirty;
   logic [TAGW-1:0]  tag_mem  [LINES];
   logic [127:0]     data_mem [LINES];

   logic [IDXW-1:0] idx;
   logic [TAGW-1:0] tag;
   logic [1:0]      word_sel;
   logic [3:0]      byte_sel;
   logic [127:0]    line;
   logic            access;
   logic            hit;
   logic            idle_hit;
   logic            store_hit;
   logic            fill_done;

   logic         stall;
   logic         req;
   logic         we;
   logic [31:0]  maddr;
   logic [127:0] mwdata;
   logic [31:0]  rd;

   assign idx      = bus.addr[4 +: IDXW];
   assign tag      = bus.addr[31:4+IDXW];
   assign word_sel = bus.addr[3:2];
   assign byte_sel = bus.addr[3:0];
   assign line     = data_mem[idx];
   assign access   = bus.MEM_R_EN | bus.MEM_W_EN;
   assign hit      = valid[idx] & (tag_mem[idx] == tag);
   assign idle_hit = (state == IDLE) & access & hit;
   // A simultaneous read and write request is a store.
   assign store_hit = idle_hit & bus.MEM_W_EN;

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      req       = 1'b0;
      we        = 1'b0;
      maddr     = '0;
      mwdata    = '0;
      fill_done = 1'b0;
      case (state)
         IDLE: begin
            if (access && !hit) begin
               stall     = 1'b1;
               state_nxt = dirty[idx] ? WB : FILL;
            end
         end
         WB: begin
            stall  = 1'b1;
            req    = 1'b1;
            we     = 1'b1;
            maddr  = {tag_mem[idx], idx, 4'b0000};
            mwdata = line;
            if (bus.mem_ack) state_nxt = FILL;
         end
         FILL: begin
            stall = 1'b1;
            req   = 1'b1;
            maddr = {tag, idx, 4'b0000};
            if (bus.mem_ack) begin
               fill_done = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rd = '0;
      if (idle_hit && !bus.MEM_W_EN) begin
         if (bus.is_byte) rd = {24'b0, line[{byte_sel, 3'b000} +: 8]};
         else             rd = line[{word_sel, 5'b00000} +: 32];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         valid <= '0;
         dirty <= '0;
      end else begin
         state <= state_nxt;
         if (fill_done) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
         end else if (store_hit) begin
            dirty[idx] <= 1'b1;
         end
      end
   end

   // Tag and data arrays carry no reset; valid gates every use of them.
   always_ff @(posedge clk) begin
      if (fill_done) begin
         data_mem[idx] <= bus.mem_rdata;
         tag_mem[idx]  <= tag;
      end else if (store_hit) begin
         if (bus.is_byte) data_mem[idx][{byte_sel, 3'b000} +: 8]  <= bus.wdata[7:0];
         else             data_mem[idx][{word_sel, 5'b00000} +: 32] <= bus.wdata;
      end
   end

`ifdef DCACHE_STATS_EN
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (idle_hit && hit_cnt != '1) hit_cnt <= hit_cnt + 16'd1;
         if ((state == IDLE) && access && !hit && miss_cnt != '1) miss_cnt <= miss_cnt + 16'd1;
      end
   end

   assign bus.hit_count  = hit_cnt;
   assign bus.miss_count = miss_cnt;
`else
   assign bus.hit_count  = '0;
   assign bus.miss_count = '0;
`endif

   assign bus.block_pipe_data_cache = stall;
   assign bus.mem_req               = req;
   assign bus.mem_we                = we;
   assign bus.mem_addr              = maddr;
   assign bus.mem_wdata             = mwdata;
   assign bus.rdata                 = rd;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed scoreboard bench for dcache_ctrl: expected values are queued as each step is driven
// and popped as the cache responds; memory transfers are acknowledged after a chosen number of cycles.
module tb_dcache_ctrl;
   logic clk = 1'b0;
   logic reset;

   dcache_ctrl_if bus ();

   dcache_ctrl #(.LINES(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        tag;
      logic [127:0] val;
   } exp_t;

   exp_t sb [$];
   int   n_assert = 0;
   int   n_fail   = 0;

   int           stalls;
   int           ntx;
   logic [31:0]  rd_hit;
   logic         tx_we   [2];
   logic [31:0]  tx_addr [2];
   logic [127:0] tx_wd   [2];

   localparam logic [127:0] L1     = 128'h44443333_22221111_BBBBAAAA_DDDDCCCC;
   localparam logic [127:0] LDIRTY = 128'h44443333_22221111_DEADBEEF_DDDDABCC;
   localparam logic [127:0] L2     = 128'hCAFEF00D_12345678_9ABCDEF0_0BADC0DE;
   localparam logic [127:0] L3     = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
   localparam logic [127:0] JUNK   = {4{32'hBAD0BAD0}};

   task automatic push_exp(input string tag, input logic [127:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic check(input logic [127:0] obs);
      exp_t e;
      n_assert++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty: observed %0h with no expected entry", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic step(input logic r, input logic w, input logic b,
                       input logic [31:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      bus.MEM_R_EN = r;
      bus.MEM_W_EN = w;
      bus.is_byte  = b;
      bus.addr     = a;
      bus.wdata    = d;
   endtask

   // Counts stall cycles of the access already driven, acknowledging the write-back after
   // wb_ack request cycles and the fill after fill_ack request cycles.
   task automatic run_access(input int wb_ack, input int fill_ack, input logic [127:0] fill_line);
      int   req_cyc;
      logic done;
      stalls  = 0;
      ntx     = 0;
      req_cyc = 0;
      done    = 1'b0;
      rd_hit  = 'x;
      for (int i = 0; i < 2; i++) begin
         tx_we[i]   = 1'bx;
         tx_addr[i] = 'x;
         tx_wd[i]   = 'x;
      end
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (!bus.block_pipe_data_cache) begin
            rd_hit = bus.rdata;
            done   = 1'b1;
         end else begin
            stalls++;
            if (bus.mem_req) begin
               if (req_cyc == 0 && ntx < 2) begin
                  tx_we[ntx]   = bus.mem_we;
                  tx_addr[ntx] = bus.mem_addr;
                  tx_wd[ntx]   = bus.mem_wdata;
               end
               req_cyc++;
               if (req_cyc == (bus.mem_we ? wb_ack : fill_ack)) begin
                  bus.mem_ack   = 1'b1;
                  bus.mem_rdata = fill_line;
                  req_cyc       = 0;
                  ntx++;
               end
            end
            @(posedge clk);
            #1;
            bus.mem_ack = 1'b0;
         end
      end
      n_assert++;
      assert (done) else begin
         n_fail++;
         $error("FAIL run_access_timeout: observed stall still high after 40 cycles, expected release");
      end
   endtask

   task automatic hit_access(input string tag, input logic r, input logic w, input logic b,
                             input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd);
      push_exp({tag, "_stall"}, 0);
      push_exp({tag, "_rdata"}, {96'b0, exp_rd});
      step(r, w, b, a, d);
      run_access(1, 1, JUNK);
      check(stalls);
      check(rd_hit);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset         = 1'b1;
      bus.MEM_R_EN  = 1'b0;
      bus.MEM_W_EN  = 1'b0;
      bus.is_byte   = 1'b0;
      bus.addr      = '0;
      bus.wdata     = '0;
      bus.mem_rdata = '0;
      bus.mem_ack   = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      push_exp("rst_mem_req", 0);    check(bus.mem_req);
      push_exp("rst_mem_we", 0);     check(bus.mem_we);
      push_exp("rst_mem_addr", 0);   check(bus.mem_addr);
      push_exp("rst_mem_wdata", 0);  check(bus.mem_wdata);
      push_exp("rst_stall_idle", 0); check(bus.block_pipe_data_cache);
      push_exp("rst_hit_count", 0);  check(bus.hit_count);
      push_exp("rst_miss_count", 0); check(bus.miss_count);
      bus.MEM_R_EN = 1'b1;
      #1;
      push_exp("rst_stall_access", 1); check(bus.block_pipe_data_cache);
      bus.MEM_R_EN = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Clean miss, fill acknowledged on the third request cycle
      push_exp("missA_stalls", 4);
      push_exp("missA_ntx", 1);
      push_exp("missA_we", 0);
      push_exp("missA_addr", 32'h40);
      push_exp("missA_rdata", 32'hDDDDCCCC);
      step(1, 0, 0, 32'h40, 0);
      run_access(1, 3, L1);
      check(stalls);
      check(ntx);
      check(tx_we[0]);
      check(tx_addr[0]);
      check(rd_hit);

      hit_access("lw48", 1, 0, 0, 32'h48, 0, 32'h22221111);
      hit_access("lw4E", 1, 0, 0, 32'h4E, 0, 32'h44443333);

      // Byte store then immediate reads of the same line
      hit_access("sb41", 0, 1, 1, 32'h41, 32'h123456AB, 32'h0);
      hit_access("lb41", 1, 0, 1, 32'h41, 0, 32'h000000AB);
      hit_access("lw40", 1, 0, 0, 32'h40, 0, 32'hDDDDABCC);

      // Both enables set: behaves as a word store
      hit_access("rw44", 1, 1, 0, 32'h44, 32'hDEADBEEF, 32'h0);
      hit_access("lw44", 1, 0, 0, 32'h44, 0, 32'hDEADBEEF);

      // Acknowledge while idle must be ignored
      step(0, 0, 0, 0, 0);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = JUNK;
      push_exp("idle_ack_req", 0);
      @(negedge clk);
      check(bus.mem_req);
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
      hit_access("idle_ack_line", 1, 0, 0, 32'h40, 0, 32'hDDDDABCC);

      // Dirty conflict miss: write-back then fill acknowledged in its first cycle
      push_exp("missB_stalls", 4);
      push_exp("missB_ntx", 2);
      push_exp("missB_wb_we", 1);
      push_exp("missB_wb_addr", 32'h40);
      push_exp("missB_wb_wdata", LDIRTY);
      push_exp("missB_fill_we", 0);
      push_exp("missB_fill_addr", 32'h100);
      push_exp("missB_rdata", 32'h0BADC0DE);
      step(1, 0, 0, 32'h100, 0);
      run_access(2, 1, L2);
      check(stalls);
      check(ntx);
      check(tx_we[0]);
      check(tx_addr[0]);
      check(tx_wd[0]);
      check(tx_we[1]);
      check(tx_addr[1]);
      check(rd_hit);

      hit_access("lb107", 1, 0, 1, 32'h107, 0, 32'h0000009A);

      // Reset asserted in the middle of a fill
      step(1, 0, 0, 32'h210, 0);
      @(negedge clk);
      @(posedge clk);
      #1;
      push_exp("rstfill_req_before", 1);
      @(negedge clk);
      check(bus.mem_req);
      reset        = 1'b1;
      bus.MEM_R_EN = 1'b0;
      #1;
      push_exp("rstfill_req", 0);   check(bus.mem_req);
      push_exp("rstfill_addr", 0);  check(bus.mem_addr);
      push_exp("rstfill_stall", 0); check(bus.block_pipe_data_cache);
      @(posedge clk);
      #1;
      reset         = 1'b0;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = JUNK;
      push_exp("rstfill_late_ack_req", 0);
      @(negedge clk);
      check(bus.mem_req);
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;

      push_exp("missC_stalls", 2);
      push_exp("missC_addr", 32'h210);
      push_exp("missC_rdata", 32'h03020100);
      step(1, 0, 0, 32'h210, 0);
      run_access(1, 1, L3);
      check(stalls);
      check(tx_addr[0]);
      check(rd_hit);

      push_exp("missD_stalls", 2);
      push_exp("missD_addr", 32'h100);
      push_exp("missD_rdata", 32'h0BADC0DE);
      step(1, 0, 0, 32'h100, 0);
      run_access(1, 1, L2);
      check(stalls);
      check(tx_addr[0]);
      check(rd_hit);

      hit_access("lw214", 1, 0, 0, 32'h214, 0, 32'h07060504);

      // Statistics since the last reset: three hits, two misses
`ifdef DCACHE_STATS_EN
      push_exp("stat_hit_count", 3);
      push_exp("stat_miss_count", 2);
`else
      push_exp("stat_hit_count", 0);
      push_exp("stat_miss_count", 0);
`endif
      step(0, 0, 0, 0, 0);
      @(negedge clk);
      check(bus.hit_count);
      check(bus.miss_count);

      n_assert++;
      assert (sb.size() == 0) else begin
         n_fail++;
         $error("FAIL scoreboard_drain: observed %0d entries left, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter: LINES, 4, number of direct-mapped lines (power of 2, >= 2); line = 16 bytes.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 MEM_R_EN  in  1  pipeline load request, held stable while stalled.
REQ-005 MEM_W_EN  in  1  pipeline store request, held stable while stalled.
REQ-006 is_byte  in  1  1 = loadb/storeb, 0 = loadw/storew.
REQ-007 addr  in  32  byte address: offset [3:0], index [3+log2(LINES):4], tag above.
REQ-008 wdata  in  32  store data; storeb uses wdata[7:0].
REQ-009 rdata  out  32  load result, combinational on hit.
REQ-010 block_pipe_data_cache  out  1  stall to pipeline control, combinational.
REQ-011 mem_req  out  1  memory transfer request.
REQ-012 mem_we  out  1  1 = write-back, 0 = fill.
REQ-013 mem_addr  out  32  line-aligned address, [3:0] = 0.
REQ-014 mem_wdata  out  128  evicted line data.
REQ-015 mem_rdata  in  128  fill data, valid when mem_ack = 1.
REQ-016 mem_ack  in  1  one-cycle transfer completion pulse.
REQ-017 hit_count, miss_count  out  16 each  statistics (see Configuration).

Function
REQ-018 Cache SHALL be direct-mapped, write-back, write-allocate, with per-line valid, dirty, tag, 128-bit data.
REQ-019 FSM states SHALL be IDLE, WB, FILL; access = MEM_R_EN | MEM_W_EN; hit = valid & tag match.
REQ-020 IDLE: access & hit -> IDLE; access & miss & dirty -> WB; access & miss & clean -> FILL.
REQ-021 WB: mem_req=1, mem_we=1, mem_addr={old tag,index,4'b0}, mem_wdata=line; on mem_ack -> FILL.
REQ-022 FILL: mem_req=1, mem_we=0, mem_addr={addr tag,index,4'b0}; on mem_ack write mem_rdata, valid=1, dirty=0, tag updated -> IDLE.
REQ-023 mem_req SHALL be 0 in IDLE; mem_ack outside WB/FILL SHALL be ignored; mem_ack in the same cycle mem_req first rises SHALL complete the transfer.
REQ-024 block_pipe_data_cache SHALL be 1 when state != IDLE or (IDLE & access & miss); 0 otherwise.
REQ-025 After FILL the retried access SHALL hit in IDLE: miss latency = fill ack cycle + 1 (clean), + write-back ack cycles (dirty).
REQ-026 Load hit: loadw returns line word addr[3:2]; loadb returns byte addr[3:0] zero-extended; rdata = 0 when no load hit.
REQ-027 Store hit: on clock edge write word addr[3:2] (storew) or byte addr[3:0] (storeb), set dirty.
REQ-028 Word accesses SHALL ignore addr[1:0].
REQ-029 MEM_R_EN and MEM_W_EN both 1 SHALL be treated as a store.
REQ-030 Store hit followed next cycle by load of same address SHALL return new data.

Reset
REQ-031 On reset: state=IDLE, all valid and dirty=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counters=0; block_pipe_data_cache follows REQ-024 (miss on any access).
REQ-032 Reset during WB or FILL SHALL abort the transfer immediately (mem_req=0 asynchronously); a later mem_ack SHALL be ignored.
REQ-033 Tag/data arrays need no reset.

Configuration
REQ-034 Macro DCACHE_STATS_EN defined: hit_count increments on each IDLE hit access, miss_count on each IDLE->WB/FILL transition; both saturate at 16'hFFFF.
REQ-035 Macro undefined: counter logic absent, hit_count and miss_count tied to 0; all other behaviour identical.

Verification
REQ-036 Reset, loadw 0x0000_0040, mem_ack 3 cycles after mem_req with line 0x44443333_22221111_... -> stall 4 cycles, mem_we=0, mem_addr=0x40, then rdata=word addr[3:2]=0, stall 0.
REQ-037 storeb 0xAB to 0x41 on hit, then loadb 0x41 -> rdata=0x0000_00AB; loadw 0x40 shows byte 1 = 0xAB.
REQ-038 Dirty line at index 0, tag A; loadw 0x0000_0100 (LINES=4, same index) -> WB with mem_addr=0x40, mem_we=1, mem_wdata=old line, then FILL mem_addr=0x100.
REQ-039 MEM_R_EN=MEM_W_EN=1, wdata=0xDEADBEEF, addr hit -> word written, dirty set, stall 0.
REQ-040 Assert reset mid-FILL -> mem_req=0 same cycle, subsequent mem_ack ignored, next access misses.
REQ-041 With DCACHE_STATS_EN: 3 hits + 2 misses -> hit_count=3 (retries included), miss_count=2; without macro both remain 0.
